// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage with a 2-entry skid buffer, registered ready and flush.
// Defining PIPE_STAGE_PERF_EN adds a saturating stall_cnt output.
module pipe_stage_skid #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] BUBBLE = 32'h0000_0013
`ifdef PIPE_STAGE_PERF_EN
  , parameter int        CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam logic [DATA_W-1:0] BUB = DATA_W'(BUBBLE);
  // bit1 is in_ready and bit0 is out_valid, so both outputs are plain flop bits
  typedef enum logic [1:0] {EMPTY = 2'b10, HALF = 2'b11, FULL = 2'b01} state_e;
  state_e state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign in_ready  = state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  always_comb begin
    state_d = flush ? EMPTY :
              (state_q == EMPTY) ? (in_fire ? HALF : EMPTY) :
              (state_q == FULL) ? (out_fire ? HALF : FULL) :
              (in_fire & !out_fire) ? FULL :
              (!in_fire & out_fire) ? EMPTY : HALF;
  end
  always_comb begin
    main_d = flush ? BUB :
             (state_q == FULL) ? (out_fire ? skid_q : main_q) :
             (in_fire & (out_fire | state_q == EMPTY)) ? in_data :
             out_fire ? BUB : main_q;
    skid_d = (state_q == HALF && in_fire && !out_fire) ? in_data : skid_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q <= BUB;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= '0;
    else if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-based reference model plus directed literal checks and random traffic.
module tb_pipe_stage_skid;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  int tests = 0, fails = 0;
  logic [31:0] mq[$];
  bit inf, outf;
`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] stall_cnt;
  int mstall = 0;
`endif

  pipe_stage_skid #(
    .DATA_W(32)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two payloads; the head is what the stage presents
  always @(posedge clk or posedge rst)
    if (rst) begin
      mq.delete();
`ifdef PIPE_STAGE_PERF_EN
      mstall = 0;
`endif
    end else begin
      inf  = in_valid && mq.size() < 2;
      outf = mq.size() > 0 && out_ready;
`ifdef PIPE_STAGE_PERF_EN
      if (mq.size() > 0 && !out_ready && mstall < 3) mstall++;
`endif
      if (flush) mq.delete();
      else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(in_data);
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("model_out_data", out_data, mq.size() > 0 ? mq[0] : 32'h13);
      chk("model_in_ready", 32'(in_ready), 32'(mq.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
      chk("model_stall_cnt", 32'(stall_cnt), 32'(mstall));
`endif
    end

  task automatic cyc(logic iv, logic [31:0] d, logic ordy, logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  task automatic expect3(string nm, logic v, logic [31:0] d, logic r);
    chk({nm, "_valid"}, 32'(out_valid), 32'(v));
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_ready"}, 32'(in_ready), 32'(r));
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    expect3("reset", 0, 32'h13, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_reset", 32'(stall_cnt), 0);
    cyc(1, 32'h1, 0, 0);
    chk("perf_c0", 32'(stall_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      chk("perf_stall", 32'(stall_cnt), i < 2 ? 32'(i + 1) : 3);
    end
    cyc(0, 0, 0, 1);
    chk("perf_flush_keeps", 32'(stall_cnt), 3);
    @(negedge clk); #2 rst = 1; #1;
    chk("perf_rst_clears", 32'(stall_cnt), 0);
    @(negedge clk); rst = 0;
`endif
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 32'(i), 1, 0);
      expect3("stream", 1, 32'(i), 1);
    end
    cyc(0, 0, 1, 0);
    expect3("stream_drain", 0, 32'h13, 1);
    cyc(1, 32'h11, 0, 0);
    expect3("bp_half", 1, 32'h11, 1);
    cyc(1, 32'h22, 0, 0);
    expect3("bp_full", 1, 32'h11, 0);
    cyc(1, 32'h33, 0, 0);
    expect3("bp_reject", 1, 32'h11, 0);
    cyc(0, 0, 1, 0);
    expect3("bp_pop1", 1, 32'h22, 1);
    cyc(1, 32'h33, 1, 0);
    expect3("bp_pop2", 1, 32'h33, 1);
    cyc(0, 0, 1, 0);
    expect3("bp_empty", 0, 32'h13, 1);
    cyc(1, 32'h55, 0, 0);
    cyc(1, 32'h66, 0, 0);
    expect3("fl_full", 1, 32'h55, 0);
    cyc(1, 32'h44, 1, 1);
    expect3("fl_full_flush", 0, 32'h13, 1);
    cyc(0, 0, 1, 0);
    expect3("fl_dropped", 0, 32'h13, 1);
    cyc(1, 32'h77, 1, 1);
    expect3("fl_empty", 0, 32'h13, 1);
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    expect3("mid_full", 1, 32'hA, 0);
    #2 rst = 1; #1;
    expect3("mid_reset", 0, 32'h13, 1);
    @(negedge clk); rst = 0;
    cyc(0, 0, 1, 0);
    expect3("after_reset", 0, 32'h13, 1);
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_data = $urandom;
      end
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
